clk_divider: RTL and testbench

CLK_DIVIDER -- requirements
Module: clk_divider

---
 rtl/clk_divider_pkg.sv | 17 +
 rtl/clk_divider_cnt.sv | 46 ++++
 rtl/clk_divider.sv | 175 +++++++++++++++++
 tb/tb_clk_divider.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_divider_pkg.sv
// clk_divider_pkg
// Shared definitions for the programmable clock divider:
//   - DEFAULT_WIDTH : default divisor / period-counter width
//   - MIN_DIV       : smallest divisor accepted by a load request
//   - state_e       : control FSM states (STOP, RUN, PEND)
package clk_divider_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int MIN_DIV       = 2;

  typedef enum logic [1:0] {
    STOP = 2'd0,  // en low, counter parked at 0, outputs low
    RUN  = 2'd1,  // dividing, no divisor waiting
    PEND = 2'd2   // dividing, a new divisor waits for the period wrap
  } state_e;

endpackage

// File: rtl/clk_divider_cnt.sv
// clk_divider_cnt
// Period counter for the clock divider. Counts 0..div_act-1 and wraps.
// Ports:
//   clk      : clock
//   rst_n    : asynchronous active-low reset (counter -> 0)
//   clr      : force the counter to 0 on the next edge (stopped / starting)
//   div_act  : currently active divisor N
//   cnt_nxt  : counter value after the next edge (used by the output flops)
//   wrap     : current cycle is the last one of the period (cnt == N-1)
module clk_divider_cnt
  import clk_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [WIDTH-1:0] div_act,
  output logic [WIDTH-1:0] cnt_nxt,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  assign wrap    = (cnt_q == (div_act - ONE));
  assign cnt_nxt = cnt_d;

  always_comb begin
    cnt_d = cnt_q + ONE;
    if (clr || wrap) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/clk_divider.sv
// clk_divider
// Programmable, glitch-free clock divider with a safe divisor-change
// handshake. A new divisor is only applied at a period boundary (or at
// once while stopped), so no output period is ever truncated or stretched.
// Optional feature: define CLK_DIVIDER_TICK_CNT_EN to add the 16-bit
// tick_cnt output (free-running count of tick pulses).
// Ports:
//   clk      : clock
//   rst_n    : asynchronous active-low reset
//   en       : 1 = divide, 0 = stopped
//   div_val  : requested divisor
//   div_load : one-cycle load request for div_val
//   div_ack  : pulse when a pending divisor becomes active
//   div_err  : pulse the cycle after a rejected (div_val < 2) load
//   pend     : an accepted divisor is waiting to be applied
//   clk_out  : divided clock (high for floor(N/2) of every N cycles)
//   tick     : pulse in the last cycle of each output period
//   tick_cnt : (CLK_DIVIDER_TICK_CNT_EN only) number of ticks, mod 2**16
module clk_divider
  import clk_divider_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int RESET_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] div_val,
  input  logic             div_load,
  output logic             div_ack,
  output logic             div_err,
  output logic             pend,
  output logic             clk_out,
  output logic             tick
`ifdef CLK_DIVIDER_TICK_CNT_EN
  ,
  output logic [15:0]      tick_cnt
`endif
);

  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] MIN_DIV_W = WIDTH'(MIN_DIV);
  localparam logic [WIDTH-1:0] RST_DIV_W = WIDTH'(RESET_DIV);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] div_act_q, div_act_d;
  logic [WIDTH-1:0] div_pend_q, div_pend_d;
  logic             pend_q, pend_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             div_ack_q, div_ack_d;
  logic             div_err_q, div_err_d;

  logic             cnt_clr;
  logic [WIDTH-1:0] cnt_nxt;
  logic             wrap;
  logic             load_ok;
  logic             apply_pend;

  // Counter parks at 0 while stopped and in the first cycle after a
  // STOP->RUN transition.
  assign cnt_clr = !en || (state_q == STOP);

  clk_divider_cnt #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cnt_clr),
    .div_act (div_act_q),
    .cnt_nxt (cnt_nxt),
    .wrap    (wrap)
  );

  always_comb begin
    state_d    = state_q;
    div_act_d  = div_act_q;
    div_pend_d = div_pend_q;
    pend_d     = pend_q;
    div_ack_d  = 1'b0;
    div_err_d  = 1'b0;
    clk_out_d  = 1'b0;
    tick_d     = 1'b0;

    load_ok = div_load && (div_val >= MIN_DIV_W);

    // A pending divisor is applied at the end of a running period, or
    // immediately when no period is in progress (stopped or stopping).
    apply_pend = pend_q && (!en || (state_q == STOP) || wrap);

    if (apply_pend) begin
      div_act_d = div_pend_q;
      div_ack_d = 1'b1;
      pend_d    = 1'b0;
    end

    // A load coinciding with an apply becomes the next pending value;
    // it is not folded into the apply happening now.
    if (load_ok) begin
      div_pend_d = div_val;
      pend_d     = 1'b1;
    end

    if (div_load && !load_ok) begin
      div_err_d = 1'b1;
    end

    if (!en) begin
      state_d = STOP;
    end else if (pend_d) begin
      state_d = PEND;
    end else begin
      state_d = RUN;
    end

    // Outputs are computed from next-state values so each output flop
    // lines up with the counter value it describes.
    if (en) begin
      clk_out_d = (cnt_nxt < (div_act_d >> 1));
      tick_d    = (cnt_nxt == (div_act_d - ONE));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= STOP;
      div_act_q  <= RST_DIV_W;
      div_pend_q <= '0;
      pend_q     <= 1'b0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
      div_ack_q  <= 1'b0;
      div_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_act_q  <= div_act_d;
      div_pend_q <= div_pend_d;
      pend_q     <= pend_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
      div_ack_q  <= div_ack_d;
      div_err_q  <= div_err_d;
    end
  end

  assign div_ack = div_ack_q;
  assign div_err = div_err_q;
  assign pend    = pend_q;
  assign clk_out = clk_out_q;
  assign tick    = tick_q;

`ifdef CLK_DIVIDER_TICK_CNT_EN
  logic [15:0] tick_cnt_q, tick_cnt_d;

  // Advances together with the tick flop; holds while stopped since
  // tick_d is forced low there. Wraps naturally at 16 bits.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (tick_d) begin
      tick_cnt_d = tick_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= 16'd0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign tick_cnt = tick_cnt_q;
`endif

endmodule

// File: tb/tb_clk_divider.sv
// tb_clk_divider
// Randomized scoreboard bench for clk_divider. The stimulus process drives
// one input set per cycle, advances a behavioural model of the divider and
// pushes the expected post-edge outputs into a queue; a monitor process
// pops one entry per cycle and compares it against the DUT.
// Build with CLK_DIVIDER_TICK_CNT_EN defined to also check tick_cnt.
module tb_clk_divider;

  localparam int WIDTH     = 8;
  localparam int RESET_DIV = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic [WIDTH-1:0] div_val = '0;
  logic             div_load = 1'b0;
  logic             div_ack, div_err, pend, clk_out, tick;
`ifdef CLK_DIVIDER_TICK_CNT_EN
  logic [15:0]      tick_cnt;
`endif

  clk_divider #(
    .WIDTH     (WIDTH),
    .RESET_DIV (RESET_DIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .div_val  (div_val),
    .div_load (div_load),
    .div_ack  (div_ack),
    .div_err  (div_err),
    .pend     (pend),
    .clk_out  (clk_out),
    .tick     (tick)
`ifdef CLK_DIVIDER_TICK_CNT_EN
    ,
    .tick_cnt (tick_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        clk_out;
    logic        tick;
    logic        ack;
    logic        err;
    logic        pend;
    logic [15:0] tcnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Behavioural model: position within the current output period, the
  // active period length, and an optional waiting divisor.
  bit m_run;
  int m_pos;
  int m_n;
  bit m_hp;
  int m_pv;
  int m_tcnt;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    m_run  = 1'b0;
    m_pos  = 0;
    m_n    = RESET_DIV;
    m_hp   = 1'b0;
    m_pv   = 0;
    m_tcnt = 0;
  endtask

  // Drive one cycle of stimulus and record what the DUT must show after
  // the edge that samples it.
  task automatic step(input bit e, input bit ld, input int v);
    exp_t x;
    bit   err, wrap, apply;
    @(posedge clk);
    #2;
    en       = e;
    div_load = ld;
    div_val  = WIDTH'(v);

    err   = ld && (v < 2);
    wrap  = m_run && (m_pos == m_n - 1);
    apply = m_hp && (!e || !m_run || wrap);
    if (apply) m_n = m_pv;
    if (ld && v >= 2) begin
      m_hp = 1'b1;
      m_pv = v;
    end else if (apply) begin
      m_hp = 1'b0;
    end
    if (!e) begin
      m_run = 1'b0;
      m_pos = 0;
    end else if (!m_run) begin
      m_run = 1'b1;
      m_pos = 0;
    end else begin
      m_pos = wrap ? 0 : m_pos + 1;
    end

    x.clk_out = m_run && (m_pos < m_n / 2);
    x.tick    = m_run && (m_pos == m_n - 1);
    if (x.tick) m_tcnt = (m_tcnt + 1) % 65536;
    x.ack  = apply;
    x.err  = err;
    x.pend = m_hp;
    x.tcnt = 16'(m_tcnt);
    exp_q.push_back(x);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_clk_out"}, 32'(clk_out), 32'd0);
    check({tag, "_tick"},    32'(tick),    32'd0);
    check({tag, "_div_ack"}, 32'(div_ack), 32'd0);
    check({tag, "_div_err"}, 32'(div_err), 32'd0);
    check({tag, "_pend"},    32'(pend),    32'd0);
`ifdef CLK_DIVIDER_TICK_CNT_EN
    check({tag, "_tick_cnt"}, 32'(tick_cnt), 32'd0);
`endif
  endtask

  // Reset pulsed between clock edges; outputs must clear without an edge.
  task automatic mid_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    exp_q.delete();
    model_reset();
    en       = 1'b0;
    div_load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_to(input int p);
    int guard = 0;
    while (m_pos != p && guard < 300) begin
      step(1'b1, 1'b0, 0);
      guard++;
    end
    check("run_to_bound", 32'(m_pos), 32'(p));
  endtask

  // Monitor: one expected entry per cycle, compared just after the edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("clk_out", 32'(clk_out), 32'(x.clk_out));
        check("tick",    32'(tick),    32'(x.tick));
        check("div_ack", 32'(div_ack), 32'(x.ack));
        check("div_err", 32'(div_err), 32'(x.err));
        check("pend",    32'(pend),    32'(x.pend));
`ifdef CLK_DIVIDER_TICK_CNT_EN
        check("tick_cnt", 32'(tick_cnt), 32'(x.tcnt));
`endif
      end
    end
  end

  initial begin
    bit e, ld;
    int v;
    model_reset();
    #3;
    check_zero("reset");
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Default divisor after reset
    repeat (12) step(1'b1, 1'b0, 0);
    // Change to 3 mid-period
    run_to(1);
    step(1'b1, 1'b1, 3);
    repeat (10) step(1'b1, 1'b0, 0);
    // Rejected loads
    step(1'b1, 1'b1, 1);
    repeat (3) step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 0);
    repeat (6) step(1'b1, 1'b0, 0);
    // Last request wins
    run_to(0);
    step(1'b1, 1'b1, 5);
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 6);
    repeat (14) step(1'b1, 1'b0, 0);
    // Stop with a divisor pending
    run_to(0);
    step(1'b1, 1'b1, 7);
    run_to(2);
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    repeat (16) step(1'b1, 1'b0, 0);
    // Reset while pending
    step(1'b1, 1'b1, 7);
    mid_reset();
    repeat (10) step(1'b1, 1'b0, 0);
    // Load while stopped, then load coinciding with a wrap
    step(1'b0, 1'b1, 2);
    repeat (3) step(1'b0, 1'b0, 0);
    repeat (3) step(1'b1, 1'b0, 0);
    run_to(1);
    step(1'b1, 1'b1, 5);
    repeat (12) step(1'b1, 1'b0, 0);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        mid_reset();
      end
      e  = ($urandom_range(0, 39) != 0);
      ld = ($urandom_range(0, 7) == 0);
      v  = $urandom_range(0, 9);
      step(e, ld, v);
    end

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
